// File: rtl/fu_arbiter_if.sv
// Bundle of every signal between the IntALU arbiter and its surroundings:
// two issue requesters, the shared combinational ALU, and the result consumer.
// Handshake: a requester transfers on a cycle where valid=1 and stall=0, and
// holds its payload stable while stall=1; the result register transfers
// downstream when res_valid=1 and res_stall=0.
// starve_cnt is a debug view of the arbiter's starvation counter.
interface fu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int RDW  = 5
);
  logic            req0_valid;
  logic            req0_stall;
  logic [OPW-1:0]  req0_op;
  logic [XLEN-1:0] req0_s1;
  logic [XLEN-1:0] req0_s2;
  logic [RDW-1:0]  req0_rd;

  logic            req1_valid;
  logic            req1_stall;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] req1_s1;
  logic [XLEN-1:0] req1_s2;
  logic [RDW-1:0]  req1_rd;

  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_s1;
  logic [XLEN-1:0] alu_s2;
  logic [XLEN-1:0] alu_d;

  logic            res_valid;
  logic            res_stall;
  logic [XLEN-1:0] res_val;
  logic [RDW-1:0]  res_rd;
  logic            res_src;

  logic [3:0]      starve_cnt;

  // Environment side: requesters, the ALU and the result consumer.
  modport master (
    output req0_valid, req0_op, req0_s1, req0_s2, req0_rd,
    input  req0_stall,
    output req1_valid, req1_op, req1_s1, req1_s2, req1_rd,
    input  req1_stall,
    input  alu_op, alu_s1, alu_s2,
    output alu_d,
    input  res_valid, res_val, res_rd, res_src,
    output res_stall,
    input  starve_cnt
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_s1, req0_s2, req0_rd,
    output req0_stall,
    input  req1_valid, req1_op, req1_s1, req1_s2, req1_rd,
    output req1_stall,
    output alu_op, alu_s1, alu_s2,
    input  alu_d,
    output res_valid, res_val, res_rd, res_src,
    input  res_stall,
    output starve_cnt
  );
endinterface

// File: rtl/fu_arbiter.sv
// Shares one combinational IntALU between the main execute pipeline (req0)
// and an auxiliary sequencer (req1). req0 has fixed priority, but after
// STARVE_LIMIT consecutive req0 grants with req1 waiting, req1 is forced in.
// The ALU result is registered with its destination and source tag.
module fu_arbiter #(
  parameter int XLEN         = 32,
  parameter int OPW          = 4,
  parameter int RDW          = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  fu_arbiter_if.slave   bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic            out_free;
  logic            forced;
  logic            gnt0;
  logic            gnt1;

  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  logic            res_valid_q;
  logic            res_valid_d;
  logic [XLEN-1:0] res_val_q;
  logic [XLEN-1:0] res_val_d;
  logic [RDW-1:0]  res_rd_q;
  logic [RDW-1:0]  res_rd_d;
  logic            res_src_q;
  logic            res_src_d;

  logic            stall0;
  logic            stall1;
  logic [OPW-1:0]  mux_op;
  logic [XLEN-1:0] mux_s1;
  logic [XLEN-1:0] mux_s2;

  // Grant decision; no grant is possible while the output register is blocked.
  always_comb begin
    out_free = !res_valid_q || !bus.res_stall;
    forced   = (cnt_q == LIMIT) && bus.req1_valid;
    gnt1     = out_free && bus.req1_valid && (forced || !bus.req0_valid);
    gnt0     = out_free && bus.req0_valid && !gnt1;
  end

  // State register: starvation counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      res_valid_q <= 1'b0;
      res_val_q   <= '0;
      res_rd_q    <= '0;
      res_src_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_val_q   <= res_val_d;
      res_rd_q    <= res_rd_d;
      res_src_q   <= res_src_d;
    end
  end

  // Next state: everything holds while blocked; on a free cycle load the grant.
  always_comb begin
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_val_d   = res_val_q;
    res_rd_d    = res_rd_q;
    res_src_d   = res_src_q;
    if (out_free) begin
      res_valid_d = gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        res_val_d = bus.alu_d;
        res_rd_d  = gnt1 ? bus.req1_rd : bus.req0_rd;
        res_src_d = gnt1;
      end
      // The counter only measures an unbroken wait by req1.
      if (gnt1 || !bus.req1_valid) begin
        cnt_d = 4'd0;
      end else if (gnt0 && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Outputs: stalls and ALU operand mux (defaults to req0 to avoid X).
  always_comb begin
    stall0 = !out_free || (bus.req0_valid && !gnt0);
    stall1 = !out_free || (bus.req1_valid && !gnt1);
    if (gnt1) begin
      mux_op = bus.req1_op;
      mux_s1 = bus.req1_s1;
      mux_s2 = bus.req1_s2;
    end else begin
      mux_op = bus.req0_op;
      mux_s1 = bus.req0_s1;
      mux_s2 = bus.req0_s2;
    end
  end

  assign bus.req0_stall = stall0;
  assign bus.req1_stall = stall1;
  assign bus.alu_op     = mux_op;
  assign bus.alu_s1     = mux_s1;
  assign bus.alu_s2     = mux_s2;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_val    = res_val_q;
  assign bus.res_rd     = res_rd_q;
  assign bus.res_src    = res_src_q;
  assign bus.starve_cnt = cnt_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter: directed scenarios followed by randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_fu_arbiter;
  localparam int XLEN  = 32;
  localparam int OPW   = 4;
  localparam int RDW   = 5;
  localparam int LIMIT = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fu_arbiter_if #(.XLEN(XLEN), .OPW(OPW), .RDW(RDW)) bus();

  fu_arbiter #(
    .XLEN(XLEN), .OPW(OPW), .RDW(RDW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU standing in for the shared IntALU.
  function automatic logic [XLEN-1:0] alu_f(input logic [OPW-1:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      default: return a ^ ~b;
    endcase
  endfunction

  assign bus.alu_d = alu_f(bus.alu_op, bus.alu_s1, bus.alu_s2);

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic            m_valid;
  logic [XLEN-1:0] m_val;
  logic [RDW-1:0]  m_rd;
  logic            m_src;
  int              m_run;
  int              last_win;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_val    = '0;
    m_rd     = '0;
    m_src    = 1'b0;
    m_run    = 0;
    last_win = -1;
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic set_req(input int idx, input bit v, input logic [OPW-1:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [RDW-1:0] rd);
    if (idx == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_s1 = a; bus.req0_s2 = b; bus.req0_rd = rd;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_s1 = a; bus.req1_s2 = b; bus.req1_rd = rd;
    end
  endtask

  task automatic rnd_req(input int idx, input bit v);
    set_req(idx, v, 4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  // New payload for whichever requester transferred last cycle; stalled ones hold.
  task automatic refresh_both();
    if (last_win == 0) rnd_req(0, 1'b1);
    if (last_win == 1) rnd_req(1, 1'b1);
  endtask

  task automatic rnd_step();
    if (!bus.req0_valid || last_win == 0) rnd_req(0, $urandom_range(0, 3) != 0);
    if (!bus.req1_valid || last_win == 1) rnd_req(1, $urandom_range(0, 2) != 0);
    bus.res_stall = ($urandom_range(0, 3) == 0);
  endtask

  // One clock: check combinational outputs mid-cycle, registered ones after the edge.
  task automatic cycle();
    bit             blocked;
    bit             w0;
    bit             w1;
    logic [RDW-1:0] g_rd;
    @(negedge clk);
    blocked = m_valid && bus.res_stall;
    w1 = !blocked && bus.req1_valid && (m_run == LIMIT || !bus.req0_valid);
    w0 = !blocked && bus.req0_valid && !w1;
    chk("req0_stall", 64'(bus.req0_stall), 64'(blocked || (bus.req0_valid && !w0)));
    chk("req1_stall", 64'(bus.req1_stall), 64'(blocked || (bus.req1_valid && !w1)));
    if (w1) begin
      chk("alu_op", 64'(bus.alu_op), 64'(bus.req1_op));
      chk("alu_s1", 64'(bus.alu_s1), 64'(bus.req1_s1));
      chk("alu_s2", 64'(bus.alu_s2), 64'(bus.req1_s2));
      exp_q.push_back(alu_f(bus.req1_op, bus.req1_s1, bus.req1_s2));
      g_rd = bus.req1_rd;
    end else begin
      chk("alu_op", 64'(bus.alu_op), 64'(bus.req0_op));
      chk("alu_s1", 64'(bus.alu_s1), 64'(bus.req0_s1));
      chk("alu_s2", 64'(bus.alu_s2), 64'(bus.req0_s2));
      if (w0) exp_q.push_back(alu_f(bus.req0_op, bus.req0_s1, bus.req0_s2));
      g_rd = bus.req0_rd;
    end
    last_win = w1 ? 1 : (w0 ? 0 : -1);
    if (!blocked) begin
      if (w1 || !bus.req1_valid) m_run = 0;
      else if (w0 && m_run < LIMIT) m_run = m_run + 1;
    end
    @(posedge clk);
    #1;
    if (!blocked) begin
      m_valid = w0 || w1;
      if (w0 || w1) begin
        m_val = exp_q.pop_front();
        m_rd  = g_rd;
        m_src = w1;
      end
    end
    chk("res_valid", 64'(bus.res_valid), 64'(m_valid));
    chk("res_val", 64'(bus.res_val), 64'(m_val));
    chk("res_rd", 64'(bus.res_rd), 64'(m_rd));
    chk("res_src", 64'(bus.res_src), 64'(m_src));
    chk("starve_cnt", 64'(bus.starve_cnt), 64'(m_run));
  endtask

  int exp_seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    bus.res_stall = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("rst_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_val", 64'(bus.res_val), 64'(0));
    chk("rst_rd", 64'(bus.res_rd), 64'(0));
    chk("rst_src", 64'(bus.res_src), 64'(0));
    chk("rst_stall0", 64'(bus.req0_stall), 64'(0));
    chk("rst_stall1", 64'(bus.req1_stall), 64'(0));
    chk("rst_cnt", 64'(bus.starve_cnt), 64'(0));
    #10 rst_n = 1'b1;
    cycle();

    // req0 alone: ADD 5+7 -> rd 3
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7, 5'd3);
    cycle();
    chk("add_valid", 64'(bus.res_valid), 64'(1));
    chk("add_val", 64'(bus.res_val), 64'(12));
    chk("add_rd", 64'(bus.res_rd), 64'(3));
    chk("add_src", 64'(bus.res_src), 64'(0));
    set_req(0, 1'b0, '0, '0, '0, '0);
    cycle();

    // Continuous contention: 0,0,0,1,0,0,0,1
    rnd_req(0, 1'b1);
    rnd_req(1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("grant_seq", 64'(last_win), 64'(exp_seq[i]));
      refresh_both();
    end

    // Downstream stall for 4 cycles with both requesters valid
    bus.res_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("hold_nogrant", 64'(last_win == -1), 64'(1));
      chk("hold_stall0", 64'(bus.req0_stall), 64'(1));
      chk("hold_stall1", 64'(bus.req1_stall), 64'(1));
      chk("hold_cnt", 64'(bus.starve_cnt), 64'(0));
    end
    bus.res_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("resume_seq", 64'(last_win), 64'(exp_seq[i]));
      refresh_both();
    end

    // Let req0 finish alone, then req1 alone: SUB 10-3 -> rd 8
    set_req(1, 1'b0, '0, '0, '0, '0);
    cycle();
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b1, 4'd1, 32'd10, 32'd3, 5'd8);
    cycle();
    chk("sub_val", 64'(bus.res_val), 64'(7));
    chk("sub_src", 64'(bus.res_src), 64'(1));
    chk("sub_rd", 64'(bus.res_rd), 64'(8));

    // Alternating single requesters: back-to-back results, no bubble
    for (int i = 0; i < 6; i++) begin
      rnd_req(i % 2, 1'b1);
      set_req(1 - (i % 2), 1'b0, '0, '0, '0, '0);
      cycle();
      chk("no_bubble", 64'(bus.res_valid), 64'(1));
      chk("alt_src", 64'(bus.res_src), 64'(i % 2));
    end

    // req1 withdraws after two req0 grants; counter restarts from zero
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    cycle();
    rnd_req(0, 1'b1);
    rnd_req(1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("wd_pre", 64'(last_win), 64'(0));
      refresh_both();
    end
    set_req(1, 1'b0, '0, '0, '0, '0);
    cycle();
    chk("wd_clear", 64'(bus.starve_cnt), 64'(0));
    refresh_both();
    rnd_req(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("wd_seq", 64'(last_win), 64'(exp_seq[i]));
      refresh_both();
    end

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.res_valid), 64'(0));
        chk("arst_val", 64'(bus.res_val), 64'(0));
        chk("arst_cnt", 64'(bus.starve_cnt), 64'(0));
        model_reset();
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        bus.res_stall = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      rnd_step();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
